// File: rtl/vx_csr_lock_ctrl.sv
// vx_csr_lock_ctrl
//   Per-warp issue throttle for FPU-CSR accesses. Every warp has a count of
//   instructions in flight. It also has a two-state lock FSM. An FPU-CSR
//   instruction locks its warp at issue, and the CSR unit releases the warp
//   later with unlock_warp. While a warp is locked, or while its in-flight
//   count is at MAX_PENDING, the warp cannot issue.
//
//   Optional feature: define CSR_LOCK_PERF_EN to add perf_lock_cycles. This
//   is a saturating 44-bit count of the cycles in which any warp is locked.
//
//   State table (one FSM per warp):
//     state     | meaning
//     ----------+-------------------------------------------------------
//     ST_ACTIVE | warp may issue (subject to the pending limit)
//     ST_LOCKED | an FPU-CSR access is outstanding; issue blocked until
//               | the CSR unit unlocks the warp
module vx_csr_lock_ctrl #(
    parameter int NUM_WARPS   = 4,
    parameter int MAX_PENDING = 15,
    parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [WID_W-1:0]     issue_wid,
    input  logic                 issue_fpu_csr,
    output logic                 issue_ready,
    input  logic                 commit_valid,
    input  logic [WID_W-1:0]     commit_wid,
    input  logic [WID_W-1:0]     alm_empty_wid,
    output logic                 alm_empty,
    input  logic                 unlock_warp,
    input  logic [WID_W-1:0]     unlock_wid,
    output logic [NUM_WARPS-1:0] lock_mask,
    output logic [1:0]           err_sticky
`ifdef CSR_LOCK_PERF_EN
    ,
    output logic [43:0]          perf_lock_cycles
`endif
);

    localparam logic [0:0]       ST_ACTIVE = 1'b0;
    localparam logic [0:0]       ST_LOCKED = 1'b1;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0]     cnt_q [NUM_WARPS];
    logic [CNT_W-1:0]     cnt_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] state_q, state_d;
    logic [1:0]           err_q, err_d;

    logic                 issue_fire;
    logic [NUM_WARPS-1:0] issue_hit;
    logic [NUM_WARPS-1:0] commit_hit;
    logic [NUM_WARPS-1:0] unlock_hit;
    logic                 underflow;
    logic                 spurious_unlock;

    // Issue gating from registered state only. An unlock in the same cycle
    // does not open the gate until the next cycle.
    assign issue_ready = (state_q[issue_wid] == ST_ACTIVE) &&
                         (cnt_q[issue_wid] < MAX_CNT);
    assign issue_fire  = issue_valid && issue_ready;

    // Zero-latency read of the registered count. Same-cycle events are not
    // bypassed, so the CSR unit sees a stable view.
    assign alm_empty   = (cnt_q[alm_empty_wid] <= CNT_ONE);

    // One-hot decode of the three per-warp events.
    always_comb begin
        issue_hit  = '0;
        commit_hit = '0;
        unlock_hit = '0;
        if (issue_fire) begin
            issue_hit[issue_wid] = 1'b1;
        end
        if (commit_valid) begin
            commit_hit[commit_wid] = 1'b1;
        end
        if (unlock_warp) begin
            unlock_hit[unlock_wid] = 1'b1;
        end
    end

    // Pending counters. An issue and a commit on one warp cancel each other.
    // A lone commit at zero holds the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            unique case ({issue_hit[w], commit_hit[w]})
                2'b10: cnt_d[w] = cnt_q[w] + CNT_ONE;
                2'b01: begin
                    if (cnt_q[w] != '0) begin
                        cnt_d[w] = cnt_q[w] - CNT_ONE;
                    end
                end
                default: cnt_d[w] = cnt_q[w];
            endcase
        end
    end

    // Lock FSMs. Issue needs ST_ACTIVE, so a lock and an unlock can never
    // hit the same warp with a conflicting transition.
    always_comb begin
        state_d = state_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (unlock_hit[w] && (state_q[w] == ST_LOCKED)) begin
                state_d[w] = ST_ACTIVE;
            end
            if (issue_hit[w] && issue_fpu_csr) begin
                state_d[w] = ST_LOCKED;
            end
        end
    end

    // Error detection and sticky accumulation.
    always_comb begin
        underflow       = commit_valid && !issue_hit[commit_wid] &&
                          (cnt_q[commit_wid] == '0);
        spurious_unlock = unlock_warp && (state_q[unlock_wid] == ST_ACTIVE);
        err_d           = err_q | {spurious_unlock, underflow};
    end

    // State registers. Reset throws away all in-flight tracking and locks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w] <= '0;
            end
            state_q <= {NUM_WARPS{ST_ACTIVE}};
            err_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Lock mask is the registered FSM state decoded per warp.
    always_comb begin
        lock_mask = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            lock_mask[w] = (state_q[w] == ST_LOCKED);
        end
    end

    assign err_sticky = err_q;

`ifdef CSR_LOCK_PERF_EN
    logic [43:0] perf_q, perf_d;

    // Count cycles with any warp locked. The count saturates, so a long run
    // does not wrap back to a small value.
    always_comb begin
        perf_d = perf_q;
        if ((lock_mask != '0) && (perf_q != '1)) begin
            perf_d = perf_q + 44'd1;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_lock_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vx_csr_lock_ctrl.sv
module tb_vx_csr_lock_ctrl;
    localparam int NW = 4;
    localparam int MP = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, issue_fpu_csr, commit_valid, unlock_warp;
    logic [1:0] issue_wid, commit_wid, alm_empty_wid, unlock_wid;
    logic       issue_ready, alm_empty;
    logic [3:0] lock_mask;
    logic [1:0] err_sticky;
`ifdef CSR_LOCK_PERF_EN
    logic [43:0] perf_lock_cycles;
`endif

    vx_csr_lock_ctrl #(.NUM_WARPS(NW), .MAX_PENDING(MP)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_wid     (issue_wid),
        .issue_fpu_csr (issue_fpu_csr),
        .issue_ready   (issue_ready),
        .commit_valid  (commit_valid),
        .commit_wid    (commit_wid),
        .alm_empty_wid (alm_empty_wid),
        .alm_empty     (alm_empty),
        .unlock_warp   (unlock_warp),
        .unlock_wid    (unlock_wid),
        .lock_mask     (lock_mask),
        .err_sticky    (err_sticky)
`ifdef CSR_LOCK_PERF_EN
        ,
        .perf_lock_cycles (perf_lock_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv; int iw; logic csr;
        logic cv; int cw;
        logic uv; int uw;
        int   aw;
    } op_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int         m_cnt [NW];
    logic [3:0] m_lock;
    logic [1:0] m_err;

    // Scoreboards: combinational {issue_ready, alm_empty}, registered {lock_mask, err_sticky}
    logic [1:0] comb_q [$];
    logic [5:0] reg_q  [$];

    function automatic logic m_ready(int w);
        return !m_lock[w] && (m_cnt[w] < MP);
    endfunction

    function automatic logic m_alm(int w);
        return m_cnt[w] <= 1;
    endfunction

    function automatic op_t mk(logic iv, int iw, logic csr, logic cv, int cw,
                               logic uv, int uw, int aw);
        op_t o;
        o.iv = iv; o.iw = iw; o.csr = csr;
        o.cv = cv; o.cw = cw; o.uv = uv; o.uw = uw; o.aw = aw;
        return o;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) m_cnt[w] = 0;
        m_lock = '0;
        m_err  = '0;
        comb_q.delete();
        reg_q.delete();
    endtask

    // Drive one cycle of stimulus at the falling edge and push the expected results.
    task automatic apply(input op_t o);
        logic fire;
        @(negedge clk);
        issue_valid   = o.iv;
        issue_wid     = 2'(o.iw);
        issue_fpu_csr = o.csr;
        commit_valid  = o.cv;
        commit_wid    = 2'(o.cw);
        unlock_warp   = o.uv;
        unlock_wid    = 2'(o.uw);
        alm_empty_wid = 2'(o.aw);
        fire = o.iv && m_ready(o.iw);
        comb_q.push_back({m_ready(o.iw), m_alm(o.aw)});
        if (!(fire && o.cv && (o.iw == o.cw))) begin
            if (fire) m_cnt[o.iw]++;
            if (o.cv) begin
                if (m_cnt[o.cw] == 0) m_err[0] = 1'b1;
                else m_cnt[o.cw]--;
            end
        end
        if (o.uv) begin
            if (m_lock[o.uw]) m_lock[o.uw] = 1'b0;
            else m_err[1] = 1'b1;
        end
        if (fire && o.csr) m_lock[o.iw] = 1'b1;
        reg_q.push_back({m_lock, m_err});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue_valid = 0; issue_fpu_csr = 0; commit_valid = 0; unlock_warp = 0;
        issue_wid = 2'd3; commit_wid = 0; alm_empty_wid = 2'd3; unlock_wid = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({issue_ready, alm_empty} !== 2'b11) begin
            n_fail++; $display("FAIL reset ready/alm got %b exp 11", {issue_ready, alm_empty});
        end
        n_checks++;
        if ({lock_mask, err_sticky} !== 6'b0) begin
            n_fail++; $display("FAIL reset lock/err got %b exp 000000", {lock_mask, err_sticky});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_pending();
        op_t ops [$];
        logic [1:0] ce; logic [5:0] re;
        repeat (3) ops.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
        ops.push_back(mk(0, 2, 0, 0, 0, 0, 0, 2));           // count 3 -> alm 0
        repeat (2) ops.push_back(mk(0, 2, 0, 1, 2, 0, 0, 2));
        ops.push_back(mk(0, 2, 0, 0, 0, 0, 0, 2));           // count 1 -> alm 1
        ops.push_back(mk(0, 2, 0, 1, 2, 0, 0, 2));
        ops.push_back(mk(0, 2, 0, 0, 0, 0, 0, 2));
        foreach (ops[i]) begin
            apply(ops[i]);
            #1; ce = comb_q.pop_front(); n_checks++;
            if ({issue_ready, alm_empty} !== ce) begin
                n_fail++; $display("FAIL pending[%0d] ready/alm got %b exp %b", i, {issue_ready, alm_empty}, ce);
            end
            @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
            if ({lock_mask, err_sticky} !== re) begin
                n_fail++; $display("FAIL pending[%0d] lock/err got %b exp %b", i, {lock_mask, err_sticky}, re);
            end
        end
    endtask

    task automatic test_lock();
        op_t ops [$];
        logic [1:0] ce; logic [5:0] re;
        ops.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));   // lock wid 1
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));   // ready 0 for wid 1
        ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   // ready 1 for wid 0
        ops.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1));   // unlock + issue: issue blocked
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        ops.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1));
        ops.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        foreach (ops[i]) begin
            apply(ops[i]);
            #1; ce = comb_q.pop_front(); n_checks++;
            if ({issue_ready, alm_empty} !== ce) begin
                n_fail++; $display("FAIL lock[%0d] ready/alm got %b exp %b", i, {issue_ready, alm_empty}, ce);
            end
            @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
            if ({lock_mask, err_sticky} !== re) begin
                n_fail++; $display("FAIL lock[%0d] lock/err got %b exp %b", i, {lock_mask, err_sticky}, re);
            end
        end
    endtask

    task automatic test_full();
        op_t ops [$];
        logic [1:0] ce; logic [5:0] re;
        repeat (MP) ops.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));
        ops.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));   // at limit: blocked
        ops.push_back(mk(0, 3, 0, 1, 3, 0, 0, 3));   // commit -> 14
        ops.push_back(mk(0, 3, 0, 0, 0, 0, 0, 3));   // ready 1
        ops.push_back(mk(1, 3, 0, 1, 3, 0, 0, 3));   // issue+commit -> stays 14
        ops.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));   // -> 15
        ops.push_back(mk(0, 3, 0, 0, 0, 0, 0, 3));   // ready 0 again
        repeat (MP) ops.push_back(mk(0, 3, 0, 1, 3, 0, 0, 3));
        ops.push_back(mk(0, 3, 0, 0, 0, 0, 0, 3));
        foreach (ops[i]) begin
            apply(ops[i]);
            #1; ce = comb_q.pop_front(); n_checks++;
            if ({issue_ready, alm_empty} !== ce) begin
                n_fail++; $display("FAIL full[%0d] ready/alm got %b exp %b", i, {issue_ready, alm_empty}, ce);
            end
            @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
            if ({lock_mask, err_sticky} !== re) begin
                n_fail++; $display("FAIL full[%0d] lock/err got %b exp %b", i, {lock_mask, err_sticky}, re);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t o;
        logic [1:0] ce; logic [5:0] re;
        for (int i = 0; i < 260; i++) begin
            if (i < 160) begin
                o.iv  = 1'($urandom_range(0, 1));
                o.iw  = $urandom_range(0, 3);
                o.csr = ($urandom_range(0, 5) == 0);
                o.cw  = $urandom_range(0, 3);
                o.cv  = ($urandom_range(0, 1) == 1) && (m_cnt[o.cw] > 0);
                o.uw  = $urandom_range(0, 3);
                o.uv  = m_lock[o.uw] && ($urandom_range(0, 2) == 0);
                o.aw  = $urandom_range(0, 3);
            end else begin
                o = mk(0, i % NW, 0, 0, 0, 0, 0, i % NW);
                for (int w = NW - 1; w >= 0; w--) begin
                    if (m_lock[w]) begin o.uv = 1; o.uw = w; end
                    if (m_cnt[w] > 0) begin o.cv = 1; o.cw = w; end
                end
            end
            apply(o);
            #1; ce = comb_q.pop_front(); n_checks++;
            if ({issue_ready, alm_empty} !== ce) begin
                n_fail++; $display("FAIL b2b[%0d] ready/alm got %b exp %b", i, {issue_ready, alm_empty}, ce);
            end
            @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
            if ({lock_mask, err_sticky} !== re) begin
                n_fail++; $display("FAIL b2b[%0d] lock/err got %b exp %b", i, {lock_mask, err_sticky}, re);
            end
        end
    endtask

    task automatic test_errors();
        op_t ops [$];
        logic [1:0] ce; logic [5:0] re;
        ops.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));   // underflow -> 01
        ops.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));   // spurious unlock -> 11
        ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        ops.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));   // still works, errors sticky
        ops.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        foreach (ops[i]) begin
            apply(ops[i]);
            #1; ce = comb_q.pop_front(); n_checks++;
            if ({issue_ready, alm_empty} !== ce) begin
                n_fail++; $display("FAIL errors[%0d] ready/alm got %b exp %b", i, {issue_ready, alm_empty}, ce);
            end
            @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
            if ({lock_mask, err_sticky} !== re) begin
                n_fail++; $display("FAIL errors[%0d] lock/err got %b exp %b", i, {lock_mask, err_sticky}, re);
            end
        end
    endtask

    task automatic test_async_reset();
        op_t ops [$];
        logic [1:0] ce; logic [5:0] re;
        ops.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2));
        ops.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
        ops.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
        foreach (ops[i]) begin
            apply(ops[i]);
            #1; ce = comb_q.pop_front(); n_checks++;
            if ({issue_ready, alm_empty} !== ce) begin
                n_fail++; $display("FAIL arst_pre[%0d] ready/alm got %b exp %b", i, {issue_ready, alm_empty}, ce);
            end
            @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
            if ({lock_mask, err_sticky} !== re) begin
                n_fail++; $display("FAIL arst_pre[%0d] lock/err got %b exp %b", i, {lock_mask, err_sticky}, re);
            end
        end
        #2;
        issue_valid = 0; issue_wid = 2'd1; alm_empty_wid = 2'd2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({lock_mask, err_sticky} !== 6'b0) begin
            n_fail++; $display("FAIL arst lock/err got %b exp 000000", {lock_mask, err_sticky});
        end
        n_checks++;
        if ({issue_ready, alm_empty} !== 2'b11) begin
            n_fail++; $display("FAIL arst ready/alm got %b exp 11", {issue_ready, alm_empty});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply(mk(1, 1, 0, 0, 0, 0, 0, 2));
        #1; ce = comb_q.pop_front(); n_checks++;
        if ({issue_ready, alm_empty} !== ce) begin
            n_fail++; $display("FAIL arst_post ready/alm got %b exp %b", {issue_ready, alm_empty}, ce);
        end
        @(posedge clk); #1; re = reg_q.pop_front(); n_checks++;
        if ({lock_mask, err_sticky} !== re) begin
            n_fail++; $display("FAIL arst_post lock/err got %b exp %b", {lock_mask, err_sticky}, re);
        end
        apply(mk(0, 1, 0, 1, 1, 0, 0, 1));
        @(posedge clk); #1;
        void'(comb_q.pop_front());
        re = reg_q.pop_front(); n_checks++;
        if ({lock_mask, err_sticky} !== re) begin
            n_fail++; $display("FAIL arst_drain lock/err got %b exp %b", {lock_mask, err_sticky}, re);
        end
    endtask

`ifdef CSR_LOCK_PERF_EN
    task automatic test_perf();
        logic [43:0] p0;
        @(negedge clk);
        p0 = perf_lock_cycles;
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0));
        repeat (9) apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk); #1;
        n_checks++;
        if (perf_lock_cycles - p0 !== 44'd10) begin
            n_fail++; $display("FAIL perf delta got %0d exp 10", perf_lock_cycles - p0);
        end
        comb_q.delete();
        reg_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_pending();
        test_lock();
        test_full();
        test_back_to_back();
        test_errors();
        test_async_reset();
`ifdef CSR_LOCK_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vx_csr_lock_ctrl.md
VX_CSR_LOCK_CTRL -- requirements
Module: VX_csr_lock_ctrl

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: number of warps tracked (power of 2, >=2); WID_W = max(1, clog2(NUM_WARPS)).
REQ-002 SHALL have parameter MAX_PENDING, default 15: per-warp in-flight instruction limit; CNT_W = clog2(MAX_PENDING+1).
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid  input  1  instruction presented for issue.
REQ-006 SHALL have port issue_wid  input  WID_W  warp of issuing instruction.
REQ-007 SHALL have port issue_fpu_csr  input  1  issuing instruction is an FPU-CSR access (addr <= FCSR).
REQ-008 SHALL have port issue_ready  output  1  issue accepted this cycle when high with issue_valid.
REQ-009 SHALL have port commit_valid  input  1  one instruction retires (eop).
REQ-010 SHALL have port commit_wid  input  WID_W  warp of retiring instruction.
REQ-011 SHALL have port alm_empty_wid  input  WID_W  warp queried by CSR unit.
REQ-012 SHALL have port alm_empty  output  1  queried warp has at most one instruction in flight.
REQ-013 SHALL have port unlock_warp  input  1  CSR unit releases a warp.
REQ-014 SHALL have port unlock_wid  input  WID_W  warp being released.
REQ-015 SHALL have port lock_mask  output  NUM_WARPS  per-warp locked state.
REQ-016 SHALL have port err_sticky  output  2  bit0 commit underflow, bit1 spurious unlock.

Function
REQ-017 SHALL hold per warp a CNT_W-bit pending counter and a 2-state FSM: ACTIVE, LOCKED.
REQ-018 issue_ready SHALL be combinational: FSM[issue_wid]==ACTIVE and count[issue_wid] < MAX_PENDING.
REQ-019 Issue fire (issue_valid && issue_ready) SHALL increment count[issue_wid] next cycle.
REQ-020 Issue fire with issue_fpu_csr SHALL move FSM[issue_wid] ACTIVE->LOCKED next cycle.
REQ-021 commit_valid SHALL decrement count[commit_wid] next cycle; at zero it SHALL hold 0 and set err_sticky[0].
REQ-022 Issue fire and commit on same warp same cycle SHALL leave that count unchanged; on different warps both apply.
REQ-023 unlock_warp on a LOCKED warp SHALL return it to ACTIVE next cycle; on an ACTIVE warp SHALL be ignored and set err_sticky[1].
REQ-024 Unlock and issue fire for the same warp in one cycle SHALL evaluate issue_ready from pre-unlock state (issue blocked; unlock applies).
REQ-025 alm_empty SHALL be combinational: count[alm_empty_wid] <= 1, from registered counts (zero-latency read, no bypass of same-cycle events).
REQ-026 lock_mask[w] SHALL equal (FSM[w]==LOCKED), registered.
REQ-027 err_sticky bits SHALL stay set until reset.

Reset
REQ-028 Reset SHALL asynchronously force all counts to 0, all FSMs to ACTIVE, lock_mask=0, err_sticky=0, perf counter=0.
REQ-029 Outputs during reset SHALL be: issue_ready=1 (valid dataflow gated upstream), alm_empty=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tracking with no residual lock.

Configuration
REQ-031 Macro CSR_LOCK_PERF_EN SHALL, when defined, add output perf_lock_cycles (44 bits), incrementing each cycle lock_mask != 0, saturating at all-ones.
REQ-032 Without CSR_LOCK_PERF_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset, issue wid=2 non-CSR x3, no commits -> count[2]=3, alm_empty(wid=2)=0; 2 commits wid=2 -> alm_empty=1.
REQ-034 Issue wid=1 fpu_csr -> lock_mask=4'b0010, issue_ready=0 for wid=1, 1 for wid=0; unlock wid=1 -> lock_mask=0 next cycle.
REQ-035 Issue wid=3 x15 -> issue_ready=0 for wid=3; one commit wid=3 -> issue_ready=1; simultaneous issue+commit wid=3 keeps count=14.
REQ-036 Commit wid=0 with count 0 -> count stays 0, err_sticky=2'b01; unlock wid=0 while ACTIVE -> err_sticky=2'b11.
REQ-037 Lock wid=1, assert reset asynchronously mid-cycle -> lock_mask=0, counts 0, err_sticky=0 immediately.
REQ-038 With CSR_LOCK_PERF_EN: lock wid=0 for 10 cycles then unlock -> perf_lock_cycles=10.
